vanilla_interrupt_ctrl: RTL and testbench
=========================================

# vanilla_interrupt_ctrl

Interrupt-entry sequencer for the vanilla core. It watches the machine CSR state (mstatus.mie, mie, mip), waits for a flushable pipeline point, and takes a pending interrupt. Taking one means pulsing interrupt_entered to the CSR file, flushing ID, and redirecting fetch to the handler. It then tracks handler residency until mret, enforces one-instruction forward progress before re-entry (required for trace single-stepping), and records worst-case entry latency.

## Interface
- pc_width_p, 22: PC width in words, matching the CSR mepc width.
- lat_width_p, 8: width of the saturating latency counters.

- clk_i  in  1  clock
- reset_n_i  in  1  async active-low reset
- mstatus_mie_i  in  1  global interrupt enable from CSR
- mie_i  in  2  enables {trace, remote} (csr_interrupt_vector_s)
- mip_i  in  2  pending {trace, remote}
- id_valid_i  in  1  valid instruction in ID that may be squashed
- exe_flushable_i  in  1  no stall, no unresolved branch/jalr in EXE
- mret_i  in  1  mret executing in EXE
- instr_executed_i  in  1  instruction moved ID->EXE this cycle
- vector_pc_i  in  pc_width_p  handler entry PC
- interrupt_entered_o  out  1  one-cycle pulse to CSR (saves mepc, clears mie)
- flush_o  out  1  squash ID; coincident with interrupt_entered_o
- pc_redirect_v_o  out  1  fetch redirect valid; coincident with interrupt_entered_o
- pc_redirect_o  out  pc_width_p  equals vector_pc_i when pc_redirect_v_o=1, else 0
- cause_o  out  2  one-hot cause latched at entry ({trace,remote})
- in_handler_o  out  1  between entry and mret
- max_latency_o  out  lat_width_p  largest ARM residency seen, saturating

## Operation
- take_c = mstatus_mie_i & |(mie_i & mip_i); ok_c = id_valid_i & exe_flushable_i.
- Cause priority: remote over trace. Cause is sampled in the cycle the FSM moves to ENTER.
- States:
  - IDLE: take_c & ok_c -> ENTER. Otherwise take_c -> ARM (wait counter cleared).
  - ARM: take_c=0 -> IDLE; the wait count is discarded and max_latency is not updated. ok_c -> ENTER; max_latency updated if the wait exceeds it. Otherwise the wait counter increments, saturating at all-ones.
  - ENTER: one cycle, always -> HANDLER. Asserts interrupt_entered_o, flush_o, pc_redirect_v_o. mret_i is ignored here.
  - HANDLER: in_handler_o=1. mret_i -> GUARD. take_c is ignored, since mie is cleared by the CSR.
  - GUARD: instr_executed_i -> IDLE. Pending interrupts are held off until one post-mret instruction has executed.
- mret_i outside HANDLER has no effect on this block.
- cause_o holds from ENTER until the next ENTER; it is 0 after reset.

## Timing
- All outputs are Moore (state/register based); no input-to-output combinational path except pc_redirect_o from vector_pc_i.
- Minimum latency: take_c & ok_c sampled at edge t puts ENTER in cycle t+1; the pulse is exactly one cycle wide.
- An ARM wait of N cycles gives an ENTER latency of N+1.
- Back-to-back: mret at t gives GUARD at t+1. instr_executed_i at t+1 gives IDLE at t+2, and the earliest re-entry is at t+3.
- Async reset, including mid-ENTER or mid-HANDLER: immediately returns to IDLE. All outputs go to 0, and the wait and max-latency counters clear.
- Wait counter width is lat_width_p. Saturation at 2^lat_width_p-1 has no wrap. max_latency_o saturates with it.

## Structure
- bsg_vanilla_pkg gains:
  - typedef enum vanilla_int_state_e {IDLE, ARM, ENTER, HANDLER, GUARD}, 3 bits
  - localparam encodings for the cause bit positions, reusing csr_interrupt_vector_s field order
- One sub-module: vanilla_sat_counter (clear/up/saturate, async active-low reset). It is instantiated for the ARM wait count; max tracking stays in this block.

## Test plan
- Remote pending, mie.remote=1, mstatus.mie=1, ok_c=1 at t -> ENTER at t+1, cause_o=2'b01, pc_redirect_o=vector_pc_i, max_latency_o=0.
- Trace and remote pending together -> cause_o=2'b01. After mret, GUARD, one executed instruction, and trace still pending -> second entry with cause_o=2'b10.
- take_c with exe_flushable_i low for 5 cycles -> ENTER 6 cycles after take_c first seen, max_latency_o=5. A later 3-cycle wait leaves it at 5.
- Enter ARM, then drop mstatus_mie_i after 2 cycles -> IDLE, no pulse, max_latency_o unchanged.
- Hold ok_c=0 for 300 cycles with lat_width_p=8 -> max_latency_o=255, no wrap.
- Assert reset_n_i low during HANDLER -> in_handler_o, cause_o, and max_latency_o go to 0 without waiting for a clock edge. The next take_c & ok_c enters normally.

Source files
------------

// File: rtl/bsg_vanilla_pkg.sv
// Shared vanilla core types: interrupt vector layout
// and interrupt-entry sequencer states.
package bsg_vanilla_pkg;

  typedef struct packed {
    logic trace;
    logic remote;
  } csr_interrupt_vector_s;

  localparam int unsigned int_remote_bit_lp = 0;
  localparam int unsigned int_trace_bit_lp  = 1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    ENTER,
    HANDLER,
    GUARD
  } vanilla_int_state_e;

  // Remote outranks trace when both are pending.
  function automatic logic [1:0] int_cause_sel(
    input logic [1:0] pend
  );
    logic [1:0] c;
    c = '0;
    if (pend[int_remote_bit_lp])
      c[int_remote_bit_lp] = 1'b1;
    else if (pend[int_trace_bit_lp])
      c[int_trace_bit_lp] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/vanilla_sat_counter.sv
// Clearable up-counter that sticks at all-ones
// instead of wrapping.
module vanilla_sat_counter #(
  parameter int width_p = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               up,
  output logic [width_p-1:0] count
);

  logic [width_p-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else if (clear)
      count_q <= '0;
    else if (up && (count_q != '1))
      count_q <= count_q + 1'b1;
  end

  assign count = count_q;

endmodule

// File: rtl/vanilla_interrupt_ctrl.sv
// Interrupt-entry sequencer: arm, enter, handler
// residency, post-mret guard, worst-case latency.
module vanilla_interrupt_ctrl
  import bsg_vanilla_pkg::*;
#(
  parameter int pc_width_p  = 22,
  parameter int lat_width_p = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   mstatus_mie_i,
  input  logic [1:0]             mie_i,
  input  logic [1:0]             mip_i,
  input  logic                   id_valid_i,
  input  logic                   exe_flushable_i,
  input  logic                   mret_i,
  input  logic                   instr_executed_i,
  input  logic [pc_width_p-1:0]  vector_pc_i,
  output logic                   interrupt_entered_o,
  output logic                   flush_o,
  output logic                   pc_redirect_v_o,
  output logic [pc_width_p-1:0]  pc_redirect_o,
  output logic [1:0]             cause_o,
  output logic                   in_handler_o,
  output logic [lat_width_p-1:0] max_latency_o
);

  vanilla_int_state_e state_q, state_n;

  logic [1:0]             pend_c;
  logic                   take_c;
  logic                   ok_c;
  logic                   wait_clear;
  logic                   wait_up;
  logic [lat_width_p-1:0] wait_cnt;
  logic [lat_width_p-1:0] res_c;
  logic [1:0]             cause_q;
  logic [lat_width_p-1:0] max_q;
  logic                   max_upd;

  assign pend_c = mie_i & mip_i;
  assign take_c = mstatus_mie_i & (|pend_c);
  assign ok_c   = id_valid_i & exe_flushable_i;

  // Residency includes the cycle that leaves ARM.
  assign res_c = (wait_cnt == '1)
               ? wait_cnt
               : wait_cnt + 1'b1;

  vanilla_sat_counter #(
    .width_p (lat_width_p)
  ) wait_ctr (
    .clk   (clk_i),
    .rst_n (reset_n_i),
    .clear (wait_clear),
    .up    (wait_up),
    .count (wait_cnt)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      state_q <= IDLE;
    else
      state_q <= state_n;
  end

  always_comb begin
    state_n    = state_q;
    wait_clear = 1'b0;
    wait_up    = 1'b0;
    max_upd    = 1'b0;
    unique case (state_q)
      IDLE: begin
        wait_clear = 1'b1;
        if (take_c && ok_c)
          state_n = ENTER;
        else if (take_c)
          state_n = ARM;
      end
      ARM: begin
        if (!take_c) begin
          state_n = IDLE;
        end else if (ok_c) begin
          state_n = ENTER;
          max_upd = res_c > max_q;
        end else begin
          wait_up = 1'b1;
        end
      end
      ENTER: state_n = HANDLER;
      HANDLER: begin
        if (mret_i)
          state_n = GUARD;
      end
      GUARD: begin
        if (instr_executed_i)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      cause_q <= '0;
    else if (state_n == ENTER)
      cause_q <= int_cause_sel(pend_c);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      max_q <= '0;
    else if (max_upd)
      max_q <= res_c;
  end

  assign interrupt_entered_o = (state_q == ENTER);
  assign flush_o             = interrupt_entered_o;
  assign pc_redirect_v_o     = interrupt_entered_o;
  assign pc_redirect_o       = interrupt_entered_o
                             ? vector_pc_i
                             : '0;
  assign cause_o             = cause_q;
  assign in_handler_o        = (state_q == HANDLER);
  assign max_latency_o       = max_q;

endmodule

// File: tb/tb_vanilla_interrupt_ctrl.sv
// Bench for vanilla_interrupt_ctrl: vector table,
// corner sequences, randomized model comparison.
module tb_vanilla_interrupt_ctrl;

  localparam int PW = 22;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          mst = 1'b0;
  logic [1:0]    mie = '0;
  logic [1:0]    mip = '0;
  logic          idv = 1'b0;
  logic          exf = 1'b0;
  logic          mret = 1'b0;
  logic          iexec = 1'b0;
  logic [PW-1:0] vpc = 22'h2abcd;

  logic          ent, flush, rv;
  logic [PW-1:0] rpc;
  logic [1:0]    cause;
  logic          inh;
  logic [LW-1:0] maxl;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  vanilla_interrupt_ctrl #(
    .pc_width_p  (PW),
    .lat_width_p (LW)
  ) dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n),
    .mstatus_mie_i       (mst),
    .mie_i               (mie),
    .mip_i               (mip),
    .id_valid_i          (idv),
    .exe_flushable_i     (exf),
    .mret_i              (mret),
    .instr_executed_i    (iexec),
    .vector_pc_i         (vpc),
    .interrupt_entered_o (ent),
    .flush_o             (flush),
    .pc_redirect_v_o     (rv),
    .pc_redirect_o       (rpc),
    .cause_o             (cause),
    .in_handler_o        (inh),
    .max_latency_o       (maxl)
  );

  // Reference model: activity flags plus the
  // current ARM residency measured in cycles.
  bit       m_enter, m_handler, m_guard, m_armed;
  int       arm_cycles;
  bit [1:0] m_cause;
  int       m_max;

  task automatic model_reset();
    m_enter = 0; m_handler = 0; m_guard = 0;
    m_armed = 0; arm_cycles = 0;
    m_cause = 0; m_max = 0;
  endtask

  function automatic bit [1:0] pick(bit [1:0] p);
    if (p[0]) return 2'b01;
    return 2'b10;
  endfunction

  task automatic model_step();
    bit take, ok;
    bit [1:0] p;
    int r;
    p = mie & mip;
    take = mst && (p != 0);
    ok = idv && exf;
    if (m_enter) begin
      m_enter = 0; m_handler = 1;
    end else if (m_handler) begin
      if (mret) begin m_handler = 0; m_guard = 1; end
    end else if (m_guard) begin
      if (iexec) m_guard = 0;
    end else if (m_armed) begin
      if (!take) begin
        m_armed = 0;
      end else if (ok) begin
        m_armed = 0; m_enter = 1; m_cause = pick(p);
        r = (arm_cycles > 255) ? 255 : arm_cycles;
        if (r > m_max) m_max = r;
      end else begin
        arm_cycles++;
      end
    end else if (take) begin
      if (ok) begin
        m_enter = 1; m_cause = pick(p);
      end else begin
        m_armed = 1; arm_cycles = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic setin(bit s, bit [1:0] e,
                       bit [1:0] p, bit v, bit f,
                       bit r, bit x);
    mst = s; mie = e; mip = p; idv = v;
    exf = f; mret = r; iexec = x;
  endtask

  task automatic check(string nm, bit e_ent,
                       bit e_inh, bit [1:0] e_c,
                       int e_max);
    logic [PW-1:0] e_pc;
    e_pc = e_ent ? vpc : '0;
    compared++;
    if (ent !== e_ent || flush !== e_ent ||
        rv !== e_ent || rpc !== e_pc ||
        inh !== e_inh || cause !== e_c ||
        maxl !== LW'(e_max)) begin
      mismatched++;
      $display("FAIL %s: got ent=%b fl=%b rv=%b pc=%h inh=%b c=%b max=%0d want ent=%b pc=%h inh=%b c=%b max=%0d",
               nm, ent, flush, rv, rpc, inh, cause, maxl,
               e_ent, e_pc, e_inh, e_c, e_max);
    end
  endtask

  task automatic check_model(string nm);
    check(nm, m_enter, m_handler, m_cause, m_max);
  endtask

  task automatic leave_handler();
    setin(0, 0, 0, 0, 0, 0, 0); tick();
    setin(0, 0, 0, 0, 0, 1, 0); tick();
    setin(0, 0, 0, 0, 0, 0, 1); tick();
    setin(0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit s; bit [1:0] e; bit [1:0] p;
    bit v; bit f; bit r; bit x;
    bit ent; bit inh; bit [1:0] c; int mx;
  } vec_t;

  vec_t vecs [18];

  initial begin
    vecs = '{
      '{1,2'b11,2'b11,1,1,0,0, 1,0,2'b01,0},
      '{0,2'b00,2'b00,0,0,0,0, 0,1,2'b01,0},
      '{0,2'b11,2'b11,1,1,0,0, 0,1,2'b01,0},
      '{0,2'b00,2'b00,0,0,1,0, 0,0,2'b01,0},
      '{1,2'b11,2'b10,1,1,0,0, 0,0,2'b01,0},
      '{1,2'b11,2'b10,1,1,0,1, 0,0,2'b01,0},
      '{1,2'b11,2'b10,1,1,0,0, 1,0,2'b10,0},
      '{0,2'b00,2'b00,0,0,0,0, 0,1,2'b10,0},
      '{0,2'b00,2'b00,0,0,1,0, 0,0,2'b10,0},
      '{0,2'b00,2'b00,0,0,0,1, 0,0,2'b10,0},
      '{1,2'b01,2'b01,1,0,0,0, 0,0,2'b10,0},
      '{1,2'b01,2'b01,1,0,0,0, 0,0,2'b10,0},
      '{0,2'b01,2'b01,1,0,0,0, 0,0,2'b10,0},
      '{1,2'b01,2'b01,0,1,0,0, 0,0,2'b10,0},
      '{1,2'b01,2'b01,1,1,0,0, 1,0,2'b01,1},
      '{0,2'b00,2'b00,0,0,0,0, 0,1,2'b01,1},
      '{0,2'b00,2'b00,0,0,1,0, 0,0,2'b01,1},
      '{0,2'b00,2'b00,0,0,0,1, 0,0,2'b01,1}
    };

    model_reset();
    #12;
    check("reset", 0, 0, 2'b00, 0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      setin(vecs[i].s, vecs[i].e, vecs[i].p,
            vecs[i].v, vecs[i].f, vecs[i].r,
            vecs[i].x);
      tick();
      check($sformatf("vec%0d", i), vecs[i].ent,
            vecs[i].inh, vecs[i].c, vecs[i].mx);
    end

    // 5-cycle ARM residency: ENTER on the 6th edge.
    for (int i = 0; i < 5; i++) begin
      setin(1, 2'b01, 2'b01, 1, 0, 0, 0);
      tick();
      check($sformatf("wait5_c%0d", i),
            0, 0, 2'b01, 1);
    end
    setin(1, 2'b01, 2'b01, 1, 1, 0, 0);
    tick();
    check("wait5_enter", 1, 0, 2'b01, 5);
    leave_handler();

    for (int i = 0; i < 3; i++) begin
      setin(1, 2'b10, 2'b10, 1, 0, 0, 0);
      tick();
    end
    setin(1, 2'b10, 2'b10, 1, 1, 0, 0);
    tick();
    check("wait3_keep", 1, 0, 2'b10, 5);
    leave_handler();

    for (int i = 0; i < 3; i++) begin
      setin(1, 2'b01, 2'b01, 1, 0, 0, 0);
      tick();
    end
    setin(0, 2'b01, 2'b01, 1, 1, 0, 0);
    tick();
    check("arm_drop", 0, 0, 2'b10, 5);
    setin(0, 2'b01, 2'b01, 1, 1, 0, 0);
    tick();
    check("arm_drop_idle", 0, 0, 2'b10, 5);

    for (int i = 0; i < 300; i++) begin
      setin(1, 2'b01, 2'b01, 0, 1, 0, 0);
      tick();
    end
    check("sat_wait", 0, 0, 2'b10, 5);
    setin(1, 2'b01, 2'b01, 1, 1, 0, 0);
    tick();
    check("sat_enter", 1, 0, 2'b01, 255);
    setin(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("sat_handler", 0, 1, 2'b01, 255);

    // Async reset in HANDLER, no clock edge needed.
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_reset", 0, 0, 2'b00, 0);
    #1;
    reset_n = 1'b1;
    setin(1, 2'b10, 2'b10, 1, 1, 0, 0);
    tick();
    check("post_reset_enter", 1, 0, 2'b10, 0);
    leave_handler();
    check_model("post_reset_idle");

    for (int i = 0; i < 3000; i++) begin
      mst   = ($urandom_range(0, 9) < 8);
      mie   = 2'($urandom);
      mip   = 2'($urandom);
      idv   = ($urandom_range(0, 9) < 6);
      exf   = ($urandom_range(0, 9) < 5);
      mret  = ($urandom_range(0, 9) < 2);
      iexec = ($urandom_range(0, 9) < 5);
      vpc   = PW'($urandom);
      tick();
      check_model($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
